// File: rtl/link_tx_scheduler_pkg.sv
// Shared types and default timing constants for the inter-board link transmit scheduler.
package link_tx_scheduler_pkg;

  localparam int unsigned DEF_MSG_W       = 64;
  localparam int unsigned DEF_REFRESH_CYC = 1_000_000;
  localparam int unsigned DEF_DONE_TO_CYC = 65_536;
  localparam int unsigned DEF_MAX_RETRY   = 3;

  // Consecutive event grants allowed before a pending state frame must win.
  localparam int unsigned STREAK_MAX = 4;

  typedef enum logic [1:0] {
    TXS_IDLE,
    TXS_LOAD,
    TXS_SEND,
    TXS_WAIT
  } txs_state_t;

  typedef enum logic {
    SRC_STATE = 1'b0,
    SRC_EVT   = 1'b1
  } tx_src_t;

  // Bits needed for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/link_tx_scheduler_arbiter.sv
// Two-way event/state priority arbiter with anti-starvation streak counter; gnt_vld is
// combinational (same cycle as request), the granted source is registered for the load cycle.
module link_tx_arbiter
  import link_tx_scheduler_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    arb_en,
  input  logic    evt_req,
  input  logic    state_req,
  output logic    gnt_vld,
  output tx_src_t gnt_src_q
);

  logic [2:0] streak_q, streak_d;
  tx_src_t    gnt_src, gnt_src_d;
  logic       starve;

  always_comb begin
    gnt_vld   = 1'b0;
    gnt_src   = SRC_STATE;
    gnt_src_d = gnt_src_q;
    streak_d  = streak_q;
    starve    = (streak_q >= 3'(STREAK_MAX)) && state_req;

    if (arb_en) begin
      if (evt_req && !starve) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_EVT;
        if (streak_q < 3'(STREAK_MAX)) begin
          streak_d = streak_q + 3'd1;
        end
      end else if (state_req) begin
        gnt_vld  = 1'b1;
        gnt_src  = SRC_STATE;
        streak_d = '0;
      end
    end

    if (gnt_vld) begin
      gnt_src_d = gnt_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q  <= '0;
      gnt_src_q <= SRC_STATE;
    end else begin
      streak_q  <= streak_d;
      gnt_src_q <= gnt_src_d;
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Shares the link between deduplicated/refreshed state frames and urgent events, one datagram at a
// time; grant-to-tx_valid is 2 cycles, holds in SEND until tx_ready and in WAIT until tx_done/timeout.
module link_tx_scheduler
  import link_tx_scheduler_pkg::*;
#(
  parameter int unsigned MSG_W       = DEF_MSG_W,
  parameter int unsigned REFRESH_CYC = DEF_REFRESH_CYC,
  parameter int unsigned DONE_TO_CYC = DEF_DONE_TO_CYC,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSG_W-1:0] state_data,
  input  logic             evt_valid,
  input  logic [MSG_W-1:0] evt_data,
  output logic             evt_ready,
  output logic [MSG_W-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             tx_done,
  output logic             tx_src,
  output logic             link_err,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned RC_W = cnt_w(REFRESH_CYC);
  localparam int unsigned TO_W = cnt_w(DONE_TO_CYC);
  localparam int unsigned RT_W = cnt_w(MAX_RETRY + 1);

  localparam logic [RC_W-1:0] REFRESH_LAST = RC_W'(REFRESH_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST      = TO_W'(DONE_TO_CYC - 1);
  localparam logic [RT_W-1:0] RETRY_LIM    = RT_W'(MAX_RETRY);

  txs_state_t       state_q, state_d;
  logic [MSG_W-1:0] tx_data_q, tx_data_d;
  logic [MSG_W-1:0] last_sent_q, last_sent_d;
  tx_src_t          tx_src_q, tx_src_d;
  logic             state_pending_q, state_pending_d;
  logic [RC_W-1:0]  refresh_cnt_q, refresh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [RT_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic             link_err_q, link_err_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic    gnt_vld;
  tx_src_t gnt_src_q;
  logic    accept;
  logic    timeout;
  logic    refresh_hit;
  logic    load_state;
  logic    load_evt;

  link_tx_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (state_q == TXS_IDLE),
    .evt_req   (evt_valid),
    .state_req (state_pending_q),
    .gnt_vld   (gnt_vld),
    .gnt_src_q (gnt_src_q)
  );

  assign accept      = (state_q == TXS_SEND) && tx_ready;
  assign timeout     = (to_cnt_q == TO_LAST);
  assign refresh_hit = (refresh_cnt_q == REFRESH_LAST);
  assign load_state  = (state_q == TXS_LOAD) && (gnt_src_q == SRC_STATE);
  assign load_evt    = (state_q == TXS_LOAD) && (gnt_src_q == SRC_EVT);

  // Transfer sequencing, timeout supervision and drop accounting.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_src_d    = tx_src_q;
    to_cnt_d    = to_cnt_q;
    retry_cnt_d = retry_cnt_q;
    link_err_d  = link_err_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      TXS_IDLE: begin
        if (gnt_vld) begin
          state_d = TXS_LOAD;
        end
      end
      TXS_LOAD: begin
        state_d     = TXS_SEND;
        tx_src_d    = gnt_src_q;
        tx_data_d   = load_state ? state_data : evt_data;
        retry_cnt_d = '0;
      end
      TXS_SEND: begin
        to_cnt_d = '0;
        if (accept) begin
          state_d = TXS_WAIT;
        end
      end
      TXS_WAIT: begin
        if (tx_done) begin
          state_d     = TXS_IDLE;
          retry_cnt_d = '0;
        end else if (timeout) begin
          if (retry_cnt_q < RETRY_LIM) begin
            state_d     = TXS_SEND;
            retry_cnt_d = retry_cnt_q + RT_W'(1);
          end else begin
            state_d     = TXS_IDLE;
            retry_cnt_d = '0;
            link_err_d  = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = TXS_IDLE;
      end
    endcase
  end

  // State-frame dedup and periodic refresh; pending is a single flag so expiries never queue.
  always_comb begin
    last_sent_d     = last_sent_q;
    state_pending_d = state_pending_q;
    refresh_cnt_d   = refresh_cnt_q + RC_W'(1);

    if ((accept && (tx_src_q == SRC_STATE)) || refresh_hit) begin
      refresh_cnt_d = '0;
    end

    if (load_state) begin
      last_sent_d     = state_data;
      state_pending_d = 1'b0;
    end else if ((state_data != last_sent_q) || refresh_hit) begin
      state_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= TXS_IDLE;
      tx_data_q       <= '0;
      tx_src_q        <= SRC_STATE;
      last_sent_q     <= '0;
      state_pending_q <= 1'b1;
      refresh_cnt_q   <= '0;
      to_cnt_q        <= '0;
      retry_cnt_q     <= '0;
      link_err_q      <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      tx_data_q       <= tx_data_d;
      tx_src_q        <= tx_src_d;
      last_sent_q     <= last_sent_d;
      state_pending_q <= state_pending_d;
      refresh_cnt_q   <= refresh_cnt_d;
      to_cnt_q        <= to_cnt_d;
      retry_cnt_q     <= retry_cnt_d;
      link_err_q      <= link_err_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign evt_ready = load_evt;
  assign tx_valid  = (state_q == TXS_SEND);
  assign tx_data   = tx_data_q;
  assign tx_src    = tx_src_q;
  assign link_err  = link_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed scenarios for link_tx_scheduler with a start-request scoreboard.
module tb_link_tx_scheduler;

  localparam int MSG_W       = 16;
  localparam int REFRESH_CYC = 100;
  localparam int DONE_TO_CYC = 50;
  localparam int MAX_RETRY   = 3;

  typedef struct packed {
    logic             src;
    logic [MSG_W-1:0] dat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [MSG_W-1:0] state_data;
  logic             evt_valid;
  logic [MSG_W-1:0] evt_data;
  logic             evt_ready;
  logic [MSG_W-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_done;
  logic             tx_src;
  logic             link_err;
  logic [7:0]       drop_cnt;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests       = 0;
  int   fails       = 0;
  int   acc_cnt     = 0;
  int   acc_cyc     = 0;
  int   cyc         = 0;
  int   evt_rdy_cnt = 0;

  link_tx_scheduler #(
    .MSG_W       (MSG_W),
    .REFRESH_CYC (REFRESH_CYC),
    .DONE_TO_CYC (DONE_TO_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state_data (state_data),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_ready  (evt_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_src     (tx_src),
    .link_err   (link_err),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every accepted start request must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && evt_ready) evt_rdy_cnt++;
    if (!rst && tx_valid && tx_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_start: observed src=%0d data=%0h expected no start", tx_src, tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("start_src", {31'd0, tx_src}, {31'd0, mon_e.src});
        check("start_data", {16'd0, tx_data}, {16'd0, mon_e.dat});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string tag);
    int n = 0;
    while (acc_cnt < target && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_arrived"}, 32'(acc_cnt >= target), 32'd1);
  endtask

  // Drive tx_done high for the whole of cycle c.
  task automatic done_at(input int c);
    while (cyc < c) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int t0;
    int a;
    int base;
    int ev;

    rst        = 1'b1;
    state_data = 16'h1234;
    evt_valid  = 1'b0;
    evt_data   = '0;
    tx_ready   = 1'b1;
    tx_done    = 1'b0;
    repeat (3) tick();

    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_evt_ready", {31'd0, evt_ready}, 32'd0);
    check("rst_tx_data", {16'd0, tx_data}, 32'd0);
    check("rst_tx_src", {31'd0, tx_src}, 32'd0);
    check("rst_link_err", {31'd0, link_err}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // First state frame, then silence until the refresh interval expires.
    exp_q.push_back({1'b0, 16'h1234});
    rst = 1'b0;
    wait_acc(1, "t1_first");
    t0 = acc_cyc;
    done_at(t0 + 10);
    exp_q.push_back({1'b0, 16'h1234});
    wait_acc(2, "t1_refresh");
    check("t1_gap_min", 32'((acc_cyc - t0) >= REFRESH_CYC), 32'd1);
    check("t1_gap_max", 32'((acc_cyc - t0) <= REFRESH_CYC + 4), 32'd1);

    // State change during WAIT must not disturb the datagram in flight.
    a = acc_cyc;
    while (cyc < a + 3) tick();
    state_data = 16'hABCD;
    while (cyc < a + 6) tick();
    check("t2_hold_data", {16'd0, tx_data}, 32'h1234);
    check("t2_hold_valid", {31'd0, tx_valid}, 32'd0);
    exp_q.push_back({1'b0, 16'hABCD});
    done_at(a + 10);
    wait_acc(3, "t2_new_state");
    done_at(acc_cyc + 10);

    // Continuous events with state pending: E,E,E,E,S,E.
    state_data = 16'h5555;
    evt_data   = 16'hE000;
    evt_valid  = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 16'(32'hE000 + k)});
    exp_q.push_back({1'b0, 16'h5555});
    exp_q.push_back({1'b1, 16'hE004});
    ev = 0;
    for (int i = 0; i < 6; i++) begin
      wait_acc(4 + i, "t3_grant");
      if (i != 4) begin
        ev++;
        evt_data = 16'(32'hE000 + ev);
      end
      if (i == 5) evt_valid = 1'b0;
      done_at(acc_cyc + 10);
    end
    check("t3_evt_ready_pulses", evt_rdy_cnt, 32'd5);

    // No tx_done at all: four identical starts, then drop.
    base      = acc_cnt;
    evt_data  = 16'hBEEF;
    evt_valid = 1'b1;
    repeat (4) exp_q.push_back({1'b1, 16'hBEEF});
    wait_acc(base + 1, "t4_try0");
    evt_valid = 1'b0;
    wait_acc(base + 4, "t4_try3");
    a = acc_cyc;
    check("t4_err_before_drop", {31'd0, link_err}, 32'd0);
    check("t4_cnt_before_drop", {24'd0, drop_cnt}, 32'd0);
    exp_q.push_back({1'b0, 16'h5555});
    while (cyc < a + DONE_TO_CYC + 1) tick();
    check("t4_link_err", {31'd0, link_err}, 32'd1);
    check("t4_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    check("t4_idle_no_valid", {31'd0, tx_valid}, 32'd0);
    wait_acc(base + 5, "t4_refresh_after_drop");
    done_at(acc_cyc + 10);

    // tx_done coincident with timeout is a success: next start is the refresh, not a resend.
    evt_data  = 16'hF00D;
    evt_valid = 1'b1;
    exp_q.push_back({1'b1, 16'hF00D});
    exp_q.push_back({1'b0, 16'h5555});
    wait_acc(base + 6, "t6_tie_send");
    evt_valid = 1'b0;
    done_at(acc_cyc + DONE_TO_CYC);
    wait_acc(base + 7, "t6_next_is_refresh");
    check("t6_drop_cnt_kept", {24'd0, drop_cnt}, 32'd1);
    done_at(acc_cyc + 10);

    // tx_done one cycle late lands in SEND and is ignored; the retry goes out.
    evt_data  = 16'hC0DE;
    evt_valid = 1'b1;
    repeat (2) exp_q.push_back({1'b1, 16'hC0DE});
    wait_acc(base + 8, "t6b_send");
    evt_valid = 1'b0;
    a = acc_cyc;
    done_at(a + DONE_TO_CYC + 1);
    wait_acc(base + 9, "t6b_resend");
    check("t6b_resend_gap", acc_cyc - a, DONE_TO_CYC + 1);
    done_at(acc_cyc + 10);
    check("t6b_drop_cnt_kept", {24'd0, drop_cnt}, 32'd1);

    // Reset while waiting for tx_done.
    evt_data  = 16'h7777;
    evt_valid = 1'b1;
    exp_q.push_back({1'b1, 16'h7777});
    wait_acc(base + 10, "t5_send");
    evt_valid = 1'b0;
    a = acc_cyc;
    while (cyc < a + 5) tick();
    rst = 1'b1;
    tick();
    check("t5_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("t5_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("t5_link_err", {31'd0, link_err}, 32'd0);
    check("t5_tx_data", {16'd0, tx_data}, 32'd0);
    check("t5_tx_src", {31'd0, tx_src}, 32'd0);
    rst = 1'b0;
    exp_q.push_back({1'b0, 16'h5555});
    wait_acc(base + 11, "t5_post_reset_state");
    done_at(acc_cyc + 10);

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    check("evt_ready_total", evt_rdy_cnt, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
